ped_walk_ctrl: RTL
==================

Name: ped_walk_ctrl

Overview:
- Pedestrian crossing controller sitting directly downstream of the intersection traffic-light FSM.
- Consumes the one-hot vehicle `light` bus and a raw pedestrian push-button.
- Debounces and latches walk requests, and grants a timed WALK / flashing-DONT_WALK sequence only while vehicle traffic is held at RED.
- Aborts to solid DONT_WALK the moment vehicles leave RED.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive high samples of ped_btn required to register a press (1..255)
- WALK_CYCLES, 20, cycles of solid WALK per grant (1..256)
- FLASH_CYCLES, 10, cycles of flashing DONT_WALK after WALK (1..256)
- FLASH_PERIOD, 2, cycles per flash half-period (1..128)

Ports:
- clk, input, 1, system clock, all state updates on rising edge
- reset, input, 1, synchronous active-high reset
- light, input, 3, vehicle light from traffic FSM: 3'b001 RED, 3'b010 GREEN, 3'b100 YELLOW
- ped_btn, input, 1, raw pedestrian button, already synchronous to clk
- walk, output, 1, WALK lamp
- dont_walk, output, 1, DONT_WALK lamp (solid or flashing)
- request_pending, output, 1, latched un-served pedestrian request
- countdown, output, 8, remaining cycles in current WALK/FLASH phase, else 0

Behaviour:
- Reset: state=IDLE, walk=0, dont_walk=1, request_pending=0, countdown=0, debounce counter=0, btn_db=0. Reset mid-sequence has the same effect.
- "RED" means light==3'b001 exactly. Any other value, including non-one-hot, is treated as not-RED.
- Debounce:
  - Counter increments on each edge with ped_btn=1, saturating at DEBOUNCE_CYCLES.
  - Counter clears on any edge with ped_btn=0.
  - btn_db rises on the edge where the counter reaches DEBOUNCE_CYCLES.
  - btn_db falls on the first edge sampling ped_btn=0.
- Request latch:
  - request_pending sets on the same edge btn_db rises.
  - It clears on the edge IDLE->WALK is taken.
  - If set and clear coincide, set wins.
  - Holding the button produces exactly one request.
- FSM (Moore; outputs decode from registered state and phase counter):
  - IDLE: walk=0, dont_walk=1, countdown=0.
    - -> WALK when request_pending=1 and RED.
  - WALK: walk=1, dont_walk=0.
    - countdown = WALK_CYCLES-1 in the first cycle, decrementing to 0.
    - -> FLASH after WALK_CYCLES cycles.
    - -> IDLE immediately (next edge) if not-RED is sampled.
  - FLASH: walk=0.
    - Phase index i runs 0..FLASH_CYCLES-1; dont_walk=1 when (i/FLASH_PERIOD) is even, else 0.
    - countdown = FLASH_CYCLES-1-i.
    - -> HOLD after FLASH_CYCLES cycles.
    - -> IDLE if not-RED is sampled.
  - HOLD: walk=0, dont_walk=1, countdown=0.
    - -> IDLE on the first edge sampling not-RED.
    - Prevents a second grant within the same RED interval.
- Abort: on not-RED in WALK or FLASH, the next cycle shows walk=0, dont_walk=1, countdown=0. A request already consumed is not restored.
- Requests arriving during WALK/FLASH/HOLD are latched and served at the next RED after passing through IDLE.
- Safety invariant: walk=1 implies dont_walk=0 and RED was sampled on the previous edge. walk and dont_walk are never both 1.
- Phase counter width is 8 bits; parameter ranges guarantee no wrap.

Test Plan:
- Reset then idle, light=3'b010, no button for 50 cycles -> walk=0, dont_walk=1, request_pending=0, countdown=0 throughout.
- Debounce: ped_btn high 3 cycles, low 1, then high 4 cycles with light=GREEN -> request_pending stays 0 during the glitch and rises after the 4th consecutive high edge; holding ped_btn 100 cycles yields one request only.
- Full grant: request pending, light switches to RED -> next cycle walk=1, countdown=19, request_pending=0. After 20 cycles: FLASH with dont_walk pattern 1,1,0,0,1,1,0,0,1,1 and countdown 9..0. Then HOLD with dont_walk=1 solid until light leaves RED.
- Abort: light goes 3'b010 at WALK countdown=7 -> next cycle walk=0, dont_walk=1, countdown=0, state IDLE, request_pending=0.
- Re-request: press during WALK -> request_pending=1 persists through FLASH/HOLD, with no second grant in the same RED. Grant occurs on the following RED entry after GREEN/YELLOW.
- Sync reset asserted mid-FLASH, including a reset pulse while ped_btn=1 -> outputs return to reset values on that edge. Debounce restarts, and a request sets only after 4 more high samples.

Source files
------------

// File: rtl/ped_walk_ctrl.sv
// ped_walk_ctrl
//   Pedestrian crossing controller downstream of the intersection traffic-light
//   FSM. Debounces the raw push-button, latches one walk request per press, and
//   grants a timed WALK then flashing DONT_WALK sequence only while vehicle
//   traffic is held at RED. Leaving RED mid-sequence aborts to solid DONT_WALK.
//
// Ports
//   clk             system clock, all state updates on the rising edge
//   reset           synchronous active-high reset
//   light[2:0]      vehicle light: 3'b001 RED, 3'b010 GREEN, 3'b100 YELLOW
//   ped_btn         raw pedestrian button, already synchronous to clk
//   walk            WALK lamp
//   dont_walk       DONT_WALK lamp (solid or flashing)
//   request_pending latched, not yet served pedestrian request
//   countdown[7:0]  cycles remaining in the current WALK/FLASH phase, else 0
//
// State table
//   state   | meaning
//   --------+-------------------------------------------------------------
//   S_IDLE  | solid DONT_WALK, waiting for a pending request during RED
//   S_WALK  | solid WALK, phase counter runs WALK_CYCLES-1 down to 0
//   S_FLASH | flashing DONT_WALK, phase counter runs FLASH_CYCLES-1 down to 0
//   S_HOLD  | solid DONT_WALK until RED ends; blocks a second grant per RED

module ped_walk_ctrl #(
    parameter int DEBOUNCE_CYCLES = 4,   // 1..255
    parameter int WALK_CYCLES     = 20,  // 1..256
    parameter int FLASH_CYCLES    = 10,  // 1..256
    parameter int FLASH_PERIOD    = 2    // 1..128
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] light,
    input  logic       ped_btn,
    output logic       walk,
    output logic       dont_walk,
    output logic       request_pending,
    output logic [7:0] countdown
);

    localparam logic [7:0] DB_MAX     = 8'(DEBOUNCE_CYCLES);
    localparam logic [7:0] DB_LAST    = 8'(DEBOUNCE_CYCLES - 1);
    localparam logic [7:0] WALK_LOAD  = 8'(WALK_CYCLES - 1);
    localparam logic [7:0] FLASH_LOAD = 8'(FLASH_CYCLES - 1);
    localparam logic [7:0] HALF_LOAD  = 8'(FLASH_PERIOD - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WALK  = 2'd1,
        S_FLASH = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    state_t     state, state_nxt;
    logic [7:0] phase_cnt, phase_cnt_nxt;
    logic [7:0] half_cnt, half_cnt_nxt;
    logic       flash_on, flash_on_nxt;

    logic [7:0] db_cnt;
    logic       btn_db;
    logic       btn_rise;
    logic       is_red;
    logic       grant;

    // Only the exact RED code counts; anything else, including corrupt
    // non-one-hot values, is treated as traffic moving.
    assign is_red = (light == 3'b001);

    // ------------------------------------------------------------------
    // Debounce: saturating run-length counter of consecutive high samples.
    // btn_rise marks the single edge where the run reaches DEBOUNCE_CYCLES,
    // so a held button yields exactly one request.
    // ------------------------------------------------------------------
    assign btn_rise = ped_btn && !btn_db && (db_cnt == DB_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            db_cnt <= 8'd0;
            btn_db <= 1'b0;
        end else if (!ped_btn) begin
            db_cnt <= 8'd0;
            btn_db <= 1'b0;
        end else begin
            if (db_cnt != DB_MAX) begin
                db_cnt <= db_cnt + 8'd1;
            end
            if (btn_rise) begin
                btn_db <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Request latch: a new press wins over the grant that consumes the
    // previous one, so a press landing on the grant edge is not lost.
    // ------------------------------------------------------------------
    assign grant = (state == S_IDLE) && request_pending && is_red;

    always_ff @(posedge clk) begin
        if (reset) begin
            request_pending <= 1'b0;
        end else if (btn_rise) begin
            request_pending <= 1'b1;
        end else if (grant) begin
            request_pending <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // FSM state and phase registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            phase_cnt <= 8'd0;
            half_cnt  <= 8'd0;
            flash_on  <= 1'b1;
        end else begin
            state     <= state_nxt;
            phase_cnt <= phase_cnt_nxt;
            half_cnt  <= half_cnt_nxt;
            flash_on  <= flash_on_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next state, phase counters and Moore outputs.
    // The phase counter is a down-counter that doubles as the countdown
    // output; terminal count 0 ends the phase. During FLASH a second
    // down-counter toggles the lamp every FLASH_PERIOD cycles, starting lit.
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt     = state;
        phase_cnt_nxt = phase_cnt;
        half_cnt_nxt  = half_cnt;
        flash_on_nxt  = flash_on;
        walk          = 1'b0;
        dont_walk     = 1'b1;
        countdown     = 8'd0;

        case (state)
            S_IDLE: begin
                phase_cnt_nxt = 8'd0;
                if (grant) begin
                    state_nxt     = S_WALK;
                    phase_cnt_nxt = WALK_LOAD;
                end
            end

            S_WALK: begin
                walk      = 1'b1;
                dont_walk = 1'b0;
                countdown = phase_cnt;
                if (!is_red) begin
                    state_nxt     = S_IDLE;
                    phase_cnt_nxt = 8'd0;
                end else if (phase_cnt == 8'd0) begin
                    state_nxt     = S_FLASH;
                    phase_cnt_nxt = FLASH_LOAD;
                    half_cnt_nxt  = HALF_LOAD;
                    flash_on_nxt  = 1'b1;
                end else begin
                    phase_cnt_nxt = phase_cnt - 8'd1;
                end
            end

            S_FLASH: begin
                dont_walk = flash_on;
                countdown = phase_cnt;
                if (!is_red) begin
                    state_nxt     = S_IDLE;
                    phase_cnt_nxt = 8'd0;
                end else if (phase_cnt == 8'd0) begin
                    state_nxt     = S_HOLD;
                    phase_cnt_nxt = 8'd0;
                end else begin
                    phase_cnt_nxt = phase_cnt - 8'd1;
                    if (half_cnt == 8'd0) begin
                        half_cnt_nxt = HALF_LOAD;
                        flash_on_nxt = ~flash_on;
                    end else begin
                        half_cnt_nxt = half_cnt - 8'd1;
                    end
                end
            end

            S_HOLD: begin
                if (!is_red) begin
                    state_nxt = S_IDLE;
                end
            end

            default: begin
                state_nxt     = S_IDLE;
                phase_cnt_nxt = 8'd0;
            end
        endcase
    end

    // Safety: the lamps are mutually exclusive and WALK only ever follows
    // an edge that sampled RED.
    a_lamps_exclusive: assert property (
        @(posedge clk) disable iff (reset) !(walk && dont_walk));

    a_walk_after_red: assert property (
        @(posedge clk) disable iff (reset) walk |-> $past(is_red));

endmodule
